// File: rtl/readout_rx_bin_classifier_multi_pkg.sv
// Shared definitions for the multi-channel I/Q binary classifier.
//   coeff_sel_e      : low two bits of the coefficient write address
//   ch_addr_width    : channel index width for a given channel count (never below 1)
//   mult_out_width   : width of the registered slope*I product
//   iq_compare_width : width of the rescaled sum compared against Q
package readout_rx_bin_classifier_multi_pkg;

  typedef enum logic [1:0] {
    SEL_INTERCEPT = 2'd0,
    SEL_SLOPE     = 2'd1,
    SEL_POLARITY  = 2'd2,
    SEL_IGNORED   = 2'd3
  } coeff_sel_e;

  function automatic int ch_addr_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  function automatic int mult_out_width(input int data_width, input int acc_width);
    return data_width + acc_width;
  endfunction

  // Dropping the DATA_WIDTH-1 fractional bits of the Q1.x slope brings the sum back to I/Q scale.
  function automatic int iq_compare_width(input int data_width, input int acc_width);
    return mult_out_width(data_width, acc_width) - (data_width - 1);
  endfunction

endpackage

// File: rtl/adder_signed_param.sv
// Combinational signed adder with selectable output slice.
//   i_a, i_b : signed IN_WIDTH operands (sum wraps at IN_WIDTH)
//   o_y      : OUT_WIDTH bits of the sum; MSBs (arithmetic shift right) when TAKE_MSB, else LSBs
module adder_signed_param #(
  parameter int IN_WIDTH  = 26,
  parameter int OUT_WIDTH = 19,
  parameter bit TAKE_MSB  = 1'b1
) (
  input  logic signed [IN_WIDTH-1:0]  i_a,
  input  logic signed [IN_WIDTH-1:0]  i_b,
  output logic signed [OUT_WIDTH-1:0] o_y
);
  logic signed [IN_WIDTH-1:0] w_sum;
  assign w_sum = i_a + i_b;

  if (TAKE_MSB) begin : g_msb
    assign o_y = OUT_WIDTH'(w_sum >>> (IN_WIDTH - OUT_WIDTH));
  end else begin : g_lsb
    assign o_y = OUT_WIDTH'(w_sum);
  end
endmodule

// File: rtl/multiplier_signed_param.sv
// Combinational signed multiplier with selectable output slice.
//   i_a, i_b : signed operands
//   o_y      : OUT_WIDTH bits of the full product; MSBs when TAKE_MSB, else LSBs
module multiplier_signed_param #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 26,
  parameter bit TAKE_MSB  = 1'b0
) (
  input  logic signed [A_WIDTH-1:0]   i_a,
  input  logic signed [B_WIDTH-1:0]   i_b,
  output logic signed [OUT_WIDTH-1:0] o_y
);
  localparam int FullWidth = A_WIDTH + B_WIDTH;

  logic signed [FullWidth-1:0] w_full;
  assign w_full = FullWidth'(i_a) * FullWidth'(i_b);

  if (TAKE_MSB) begin : g_msb
    assign o_y = OUT_WIDTH'(w_full >>> (FullWidth - OUT_WIDTH));
  end else begin : g_lsb
    assign o_y = OUT_WIDTH'(w_full);
  end
endmodule

// File: rtl/readout_rx_bin_classifier_multi_rr_arbiter.sv
// Round-robin arbiter: picks the first pending channel at or above the rr pointer (with wrap).
//   i_clk, i_rst  : clock, synchronous active-high reset (pointer -> 0)
//   i_pending     : request vector
//   o_grant       : one-hot grant
//   o_grant_idx   : index of the granted channel
//   o_grant_valid : any grant this cycle; pointer moves to granted index + 1
module readout_rx_rr_arbiter #(
  parameter int NUM_CHANNELS  = 4,
  parameter int CH_ADDR_WIDTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CHANNELS-1:0]  i_pending,
  output logic [NUM_CHANNELS-1:0]  o_grant,
  output logic [CH_ADDR_WIDTH-1:0] o_grant_idx,
  output logic                     o_grant_valid
);
  logic [CH_ADDR_WIDTH-1:0] r_rr_ptr;
  logic [CH_ADDR_WIDTH-1:0] w_rr_next;

  always_comb begin
    logic [CH_ADDR_WIDTH-1:0] w_c;
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_c           = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_c = CH_ADDR_WIDTH'((int'(r_rr_ptr) + i) % NUM_CHANNELS);
      if (!o_grant_valid && i_pending[w_c]) begin
        o_grant[w_c]  = 1'b1;
        o_grant_idx   = w_c;
        o_grant_valid = 1'b1;
      end
    end
    w_rr_next = (int'(o_grant_idx) == NUM_CHANNELS - 1) ? '0 : o_grant_idx + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else if (o_grant_valid) begin
      r_rr_ptr <= w_rr_next;
    end
  end
endmodule

// File: rtl/readout_rx_bin_classifier_multi.sv
// Multi-channel linear I/Q classifier: decides |1> iff (slope*I + intercept) > Q, optionally
// inverted per channel, with finished channels queued and served round-robin by one shared pipe.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_coeff_wr_en/addr/data : coefficient write, addr = {channel, sel}
//   i_finish_count          : per-channel integration-done pulse
//   i_i_sum, i_q_sum        : packed signed I/Q sums, ch0 in LSBs
//   o_result_valid          : one-cycle result strobe (no backpressure)
//   o_result_channel        : channel of the result
//   o_meas_result_condition : decision, 1 = |1>
//   o_pending_overflow      : sticky per-channel "sample dropped" flags
module readout_rx_bin_classifier_multi
  import readout_rx_bin_classifier_multi_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int CH_ADDR_WIDTH     = ch_addr_width(NUM_CHANNELS),
  parameter int DATA_WIDTH        = 8,
  parameter int ACCUMULATOR_WIDTH = DATA_WIDTH + 10
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_coeff_wr_en,
  input  logic [CH_ADDR_WIDTH+1:0]                  i_coeff_wr_addr,
  input  logic [DATA_WIDTH-1:0]                     i_coeff_wr_data,
  input  logic [NUM_CHANNELS-1:0]                   i_finish_count,
  input  logic [NUM_CHANNELS*ACCUMULATOR_WIDTH-1:0] i_i_sum,
  input  logic [NUM_CHANNELS*ACCUMULATOR_WIDTH-1:0] i_q_sum,
  output logic                                      o_result_valid,
  output logic [CH_ADDR_WIDTH-1:0]                  o_result_channel,
  output logic                                      o_meas_result_condition,
  output logic [NUM_CHANNELS-1:0]                   o_pending_overflow
);
  localparam int MulW = mult_out_width(DATA_WIDTH, ACCUMULATOR_WIDTH);
  localparam int CmpW = iq_compare_width(DATA_WIDTH, ACCUMULATOR_WIDTH);
  localparam int AccW = ACCUMULATOR_WIDTH;

  // Coefficient bank; out-of-range channels never match the per-channel decode.
  logic signed [DATA_WIDTH-1:0] r_slope [NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0] r_icpt  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]      r_pol;
  logic [CH_ADDR_WIDTH-1:0]     w_wr_ch;
  coeff_sel_e                   w_wr_sel;

  assign w_wr_ch  = i_coeff_wr_addr[CH_ADDR_WIDTH+1:2];
  assign w_wr_sel = coeff_sel_e'(i_coeff_wr_addr[1:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_slope[k] <= '0;
        r_icpt[k]  <= '0;
      end
      r_pol <= '0;
    end else if (i_coeff_wr_en) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (w_wr_ch == CH_ADDR_WIDTH'(k)) begin
          case (w_wr_sel)
            SEL_INTERCEPT: r_icpt[k]  <= i_coeff_wr_data;
            SEL_SLOPE:     r_slope[k] <= i_coeff_wr_data;
            SEL_POLARITY:  r_pol[k]   <= i_coeff_wr_data[0];
            default:       ;
          endcase
        end
      end
    end
  end

  // Pending buffer: one sample slot per channel.
  logic [NUM_CHANNELS-1:0]  r_pending, r_overflow;
  logic [NUM_CHANNELS-1:0]  w_grant, w_capture, w_drop;
  logic [CH_ADDR_WIDTH-1:0] w_grant_idx;
  logic                     w_grant_valid;
  logic signed [AccW-1:0]   r_i_buf [NUM_CHANNELS];
  logic signed [AccW-1:0]   r_q_buf [NUM_CHANNELS];

  // A slot being granted this cycle is free to refill; otherwise a still-pending slot drops.
  assign w_capture = i_finish_count & (~r_pending | w_grant);
  assign w_drop    = i_finish_count & r_pending & ~w_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending  <= '0;
      r_overflow <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_i_buf[k] <= '0;
        r_q_buf[k] <= '0;
      end
    end else begin
      r_pending  <= (r_pending & ~w_grant) | w_capture;
      r_overflow <= r_overflow | w_drop;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (w_capture[k]) begin
          r_i_buf[k] <= i_i_sum[k*AccW +: AccW];
          r_q_buf[k] <= i_q_sum[k*AccW +: AccW];
        end
      end
    end
  end

  readout_rx_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_ADDR_WIDTH(CH_ADDR_WIDTH)
  ) u_arbiter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pending    (r_pending),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_grant_valid(w_grant_valid)
  );

  // Issue + S1: coefficients are read from the bank here, so they travel with the sample.
  logic signed [AccW-1:0]       w_iss_i, w_iss_q;
  logic signed [DATA_WIDTH-1:0] w_iss_slope;
  logic signed [MulW-1:0]       w_prod;

  assign w_iss_i     = r_i_buf[w_grant_idx];
  assign w_iss_q     = r_q_buf[w_grant_idx];
  assign w_iss_slope = r_slope[w_grant_idx];

  multiplier_signed_param #(
    .A_WIDTH  (AccW),
    .B_WIDTH  (DATA_WIDTH),
    .OUT_WIDTH(MulW),
    .TAKE_MSB (1'b0)
  ) u_mult (
    .i_a(w_iss_i),
    .i_b(w_iss_slope),
    .o_y(w_prod)
  );

  logic                         r_s1_valid, r_s1_pol;
  logic [CH_ADDR_WIDTH-1:0]     r_s1_ch;
  logic signed [MulW-1:0]       r_s1_prod;
  logic signed [AccW-1:0]       r_s1_q;
  logic signed [DATA_WIDTH-1:0] r_s1_icpt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pol   <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_prod  <= '0;
      r_s1_q     <= '0;
      r_s1_icpt  <= '0;
    end else begin
      r_s1_valid <= w_grant_valid;
      r_s1_pol   <= r_pol[w_grant_idx];
      r_s1_ch    <= w_grant_idx;
      r_s1_prod  <= w_prod;
      r_s1_q     <= w_iss_q;
      r_s1_icpt  <= r_icpt[w_grant_idx];
    end
  end

  // S2: intercept is added at product scale, so it is effectively scaled by 2^-(DATA_WIDTH-1).
  logic signed [MulW-1:0] w_icpt_ext;
  logic signed [CmpW-1:0] w_sum_shift, w_q_ext;
  logic                   w_dec;

  assign w_icpt_ext = MulW'(r_s1_icpt);
  assign w_q_ext    = CmpW'(r_s1_q);

  adder_signed_param #(
    .IN_WIDTH (MulW),
    .OUT_WIDTH(CmpW),
    .TAKE_MSB (1'b1)
  ) u_add (
    .i_a(r_s1_prod),
    .i_b(w_icpt_ext),
    .o_y(w_sum_shift)
  );

  assign w_dec = (w_sum_shift > w_q_ext) ^ r_s1_pol;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result_valid          <= 1'b0;
      o_result_channel        <= '0;
      o_meas_result_condition <= 1'b0;
    end else begin
      o_result_valid          <= r_s1_valid;
      o_result_channel        <= r_s1_ch;
      o_meas_result_condition <= w_dec;
    end
  end

  assign o_pending_overflow = r_overflow;
endmodule

// File: tb/tb_readout_rx_bin_classifier_multi.sv
module tb_readout_rx_bin_classifier_multi;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 18;
  localparam int CAW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [CAW+1:0]  wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic [N-1:0]    fin = '0;
  logic [N*AW-1:0] isum = '0;
  logic [N*AW-1:0] qsum = '0;
  logic            res_valid;
  logic [CAW-1:0]  res_ch;
  logic            res_cond;
  logic [N-1:0]    ovf;

  readout_rx_bin_classifier_multi #(
    .NUM_CHANNELS     (N),
    .CH_ADDR_WIDTH    (CAW),
    .DATA_WIDTH       (DW),
    .ACCUMULATOR_WIDTH(AW)
  ) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_coeff_wr_en          (wr_en),
    .i_coeff_wr_addr        (wr_addr),
    .i_coeff_wr_data        (wr_data),
    .i_finish_count         (fin),
    .i_i_sum                (isum),
    .i_q_sum                (qsum),
    .o_result_valid         (res_valid),
    .o_result_channel       (res_ch),
    .o_meas_result_condition(res_cond),
    .o_pending_overflow     (ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    bit          dec;
    int unsigned when;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;

  // Reference model state
  longint       m_slope [N];
  longint       m_icpt  [N];
  bit           m_pol   [N];
  longint       m_i     [N];
  longint       m_q     [N];
  bit           m_pend  [N];
  int           m_rr;
  logic [N-1:0] m_ovf = '0;

  function automatic bit decide(longint iv, longint qv, longint sl, longint ic, bit pol);
    longint s;
    s = (iv * sl + ic) >>> (DW - 1);
    return (s > qv) ^ pol;
  endfunction

  // Applies the inputs about to be sampled by the next rising edge to the model.
  task automatic model_update();
    int g;
    int c;
    int wch;
    int sel;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_slope[k] = 0; m_icpt[k] = 0; m_pol[k] = 0; m_pend[k] = 0;
        m_i[k] = 0; m_q[k] = 0;
      end
      m_rr  = 0;
      m_ovf = '0;
      sb.delete();
      return;
    end
    g = -1;
    for (int i = 0; i < N; i++) begin
      c = (m_rr + i) % N;
      if (g < 0 && m_pend[c]) g = c;
    end
    if (g >= 0) begin
      exp_t e;
      m_pend[g] = 0;
      m_rr      = (g + 1) % N;
      e.ch      = g;
      e.dec     = decide(m_i[g], m_q[g], m_slope[g], m_icpt[g], m_pol[g]);
      e.when    = cyc + 2;
      sb.push_back(e);
    end
    if (wr_en) begin
      wch = int'(wr_addr[CAW+1:2]);
      sel = int'(wr_addr[1:0]);
      if (wch < N) begin
        if (sel == 0) m_icpt[wch] = longint'($signed(wr_data));
        else if (sel == 1) m_slope[wch] = longint'($signed(wr_data));
        else if (sel == 2) m_pol[wch] = wr_data[0];
      end
    end
    for (int k = 0; k < N; k++) begin
      if (fin[k]) begin
        if (m_pend[k]) begin
          m_ovf[k] = 1'b1;
        end else begin
          m_pend[k] = 1;
          m_i[k]    = longint'($signed(isum[k*AW +: AW]));
          m_q[k]    = longint'($signed(qsum[k*AW +: AW]));
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_ch(input int k, input int iv, input int qv);
    isum[k*AW +: AW] = AW'(iv);
    qsum[k*AW +: AW] = AW'(qv);
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    wr_en   = 1'b1;
    wr_addr = (CAW+2)'(ch * 4 + sel);
    wr_data = DW'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic finish(input logic [N-1:0] m);
    fin = m;
    tick();
    fin = '0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_on) begin
      while (sb.size() > 0 && sb[0].when < cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_result: got none required ch=%0d cond=%0d at cycle %0d",
                 e.ch, e.dec, e.when);
      end
      if (res_valid) begin
        n_cmp++;
        if (sb.size() == 0 || sb[0].when != cyc) begin
          n_bad++;
          $display("FAIL unexpected_result: got ch=%0d cond=%0d at cycle %0d required none",
                   res_ch, res_cond, cyc);
        end else begin
          e = sb.pop_front();
          if (int'(res_ch) != e.ch || res_cond !== e.dec) begin
            n_bad++;
            $display("FAIL result: got ch=%0d cond=%0d required ch=%0d cond=%0d at cycle %0d",
                     res_ch, res_cond, e.ch, e.dec, cyc);
          end
        end
      end
      n_cmp++;
      if (ovf !== m_ovf) begin
        n_bad++;
        $display("FAIL overflow: got %b required %b at cycle %0d", ovf, m_ovf, cyc);
      end
    end
  end

  initial begin
    int fins;
    logic [N-1:0] m;
    @(negedge clk);
    rst = 1'b1;
    tick();
    mon_on = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_valid", 32'(res_valid), 32'd0);
    check("reset_channel", 32'(res_ch), 32'd0);
    check("reset_cond", 32'(res_cond), 32'd0);
    check("reset_overflow", 32'(ovf), 32'd0);

    // Basic decisions, incl. strict > at equality
    wr(0, 1, 8'h40);
    set_ch(0, 100, 40); finish(4'b0001); idle(4);
    set_ch(0, 100, 60); finish(4'b0001); idle(4);
    set_ch(0, 100, 50); finish(4'b0001); idle(4);

    // Four-way contention, then a second burst
    wr(1, 1, 8'h40);
    wr(2, 1, 8'h40);
    set_ch(0, 100, 40); set_ch(1, 100, 40); set_ch(2, 100, 60); set_ch(3, 100, 0);
    finish(4'b1111); idle(6);
    set_ch(0, 100, 60); set_ch(1, -100, -60); set_ch(2, 100, 40); set_ch(3, 5, -1);
    finish(4'b1111); idle(6);

    // Polarity inversion
    wr(2, 2, 1);
    set_ch(2, 100, 40); finish(4'b0100); idle(4);
    wr(2, 2, 0);
    finish(4'b0100); idle(4);

    // Same channel finishes again while still pending
    set_ch(0, 100, 40); set_ch(1, 100, 40);
    finish(4'b0011);
    set_ch(1, 100, 60);
    finish(4'b0010); idle(5);
    check("overflow_ch1", 32'(ovf), 32'b0010);

    // Slope write in the issue cycle of ch3
    wr(3, 1, 8'h40);
    set_ch(3, 100, 40);
    fin = 4'b1000;
    tick();
    fin     = '0;
    wr_en   = 1'b1;
    wr_addr = 4'(3 * 4 + 1);
    wr_data = 8'h20;
    tick();
    wr_en = 1'b0;
    idle(4);
    finish(4'b1000); idle(4);

    // Reset right after a burst
    for (int k = 0; k < N; k++) set_ch(k, 100, 40);
    finish(4'b1111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(6);
    check("post_reset_overflow", 32'(ovf), 32'd0);
    set_ch(0, 100, -1); finish(4'b0001); idle(4);

    // Randomized traffic
    fins = 0;
    while (fins < 10000) begin
      if ($urandom_range(0, 99) < 8) begin
        wr_en   = 1'b1;
        wr_addr = (CAW+2)'($urandom);
        wr_data = DW'($urandom);
      end
      m = N'($urandom);
      if ($urandom_range(0, 1) == 1) m = m & N'($urandom);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 9) == 0)
          set_ch(k, int'($signed(AW'($urandom))), int'($signed(AW'($urandom))));
        else
          set_ch(k, int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 2400)) - 1200);
      end
      fin = m;
      rst = ($urandom_range(0, 999) == 0);
      fins += $countones(m);
      tick();
      fin   = '0;
      wr_en = 1'b0;
      rst   = 1'b0;
    end
    idle(10);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d results outstanding required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
